// File: rtl/sram_pipe_pkg.sv
// Shared types and sizing helpers for the pipelined SRAM block.
package sram_pipe_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_e;

  function automatic int unsigned outq_depth(input int unsigned rd_lat);
    return rd_lat + 1;
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned outq);
    return $clog2(outq + 1);
  endfunction

endpackage

// File: rtl/sram_pipe_rsp_fifo.sv
// First-word-fall-through response FIFO; output reads as zero when empty.
module sram_pipe_rsp_fifo #(
  parameter int unsigned W = 33,
  parameter int unsigned D = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned CW = $clog2(D + 1);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && ((cnt_q != CW'(D)) || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == PW'(D - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == PW'(D - 1)) ? '0 : rd_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/sram_pipe.sv
// Single-port SRAM with byte enables, fixed read latency and a response FIFO.
// Define SRAM_PIPE_INIT_CLEAR_EN to zero the array in INIT after every reset.
module sram_pipe
  import sram_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [WIDTH/8-1:0]            req_be,
  input  logic [addr_width(DEPTH)-1:0]  req_addr,
  input  logic [WIDTH-1:0]              req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WIDTH-1:0]              rsp_rdata,
  output logic                          rsp_err
);

  localparam int unsigned OUTQ = outq_depth(RD_LAT);
  localparam int unsigned AW   = addr_width(DEPTH);
  localparam int unsigned CW   = cnt_width(OUTQ);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic          addr_ok, wr_acc, rd_acc, pop;
  logic [WIDTH:0] rd_word, push_data, fifo_data;
  logic          push;
  logic          sweep_we;
  logic [AW-1:0] sweep_addr;

  if (DEPTH == (1 << AW)) begin : g_full
    assign addr_ok = 1'b1;
  end else begin : g_part
    assign addr_ok = (req_addr < AW'(DEPTH));
  end

  assign req_ready = (state_q == RUN) && (cnt_q < CW'(OUTQ));
  assign wr_acc    = req_valid && req_ready && req_we;
  assign rd_acc    = req_valid && req_ready && !req_we;
  assign pop       = rsp_valid && rsp_ready;
  assign rd_word   = addr_ok ? {1'b0, mem_q[req_addr]} : {1'b1, {WIDTH{1'b0}}};

`ifdef SRAM_PIPE_INIT_CLEAR_EN
  logic [AW-1:0] clr_q, clr_d;
  assign sweep_we   = reset && (state_q == INIT);
  assign sweep_addr = clr_q;
`else
  assign sweep_we   = 1'b0;
  assign sweep_addr = '0;
`endif

  always_comb begin
    state_d = state_q;
`ifdef SRAM_PIPE_INIT_CLEAR_EN
    clr_d = clr_q;
`endif
    case (state_q)
      INIT: begin
`ifdef SRAM_PIPE_INIT_CLEAR_EN
        clr_d = clr_q + 1'b1;
        if (clr_q == AW'(DEPTH - 1)) state_d = RUN;
`else
        state_d = RUN;
`endif
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (rd_acc && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!rd_acc && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
`ifdef SRAM_PIPE_INIT_CLEAR_EN
      clr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SRAM_PIPE_INIT_CLEAR_EN
      clr_q   <= clr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_addr] <= '0;
    end else if (wr_acc && addr_ok) begin
      for (int unsigned b = 0; b < WIDTH / 8; b++) begin
        if (req_be[b]) mem_q[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
      end
    end
  end

  // The FIFO entry register is the last of the RD_LAT stages, so only
  // RD_LAT-1 registers sit between the array read and the FIFO push.
  if (RD_LAT == 1) begin : g_nopipe
    assign push      = rd_acc;
    assign push_data = rd_word;
  end else begin : g_pipe
    localparam int unsigned PL = RD_LAT - 1;
    logic [PL-1:0] vld_q;
    logic [WIDTH:0] dat_q [PL];

    always_ff @(posedge clk) begin
      if (!reset) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= rd_acc;
        for (int unsigned i = 1; i < PL; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dat_q[0] <= rd_word;
      for (int unsigned i = 1; i < PL; i++) dat_q[i] <= dat_q[i-1];
    end

    assign push      = vld_q[PL-1];
    assign push_data = dat_q[PL-1];
  end

  sram_pipe_rsp_fifo #(
    .W (WIDTH + 1),
    .D (OUTQ)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .valid_o (rsp_valid),
    .data_o  (fifo_data)
  );

  assign rsp_err   = fifo_data[WIDTH];
  assign rsp_rdata = fifo_data[WIDTH-1:0];

endmodule
